instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Reader end of the instruction-address path: generates fetch addresses, reads instruction memory
//  over a valid/ready request + valid response interface, and buffers {pc, instr} pairs for decode.
//  Sits between instruction memory and the decoder; supports a one-cycle redirect (flush) on branch/jump.
//  At most one memory request is in flight.
// PARAMETERS
//  ADDR_W    16       fetch address / PC width (word-addressed, +1 per instruction)
//  DATA_W    16       instruction width
//  DEPTH     2        prefetch buffer entries (>=1)
//  RESET_PC  16'h0000 fetch address loaded on reset
// PORTS
//  clk            in   1       rising-edge clock
//  reset          in   1       asynchronous, active-low reset
//  fetch_en       in   1       1 = allowed to issue new memory requests
//  flush          in   1       redirect: discard buffer and in-flight data, restart at flush_pc
//  flush_pc       in   ADDR_W  new fetch address, sampled when flush=1
//  imem_req_valid out  1       read request valid
//  imem_req_ready in   1       memory accepts request
//  imem_addr      out  ADDR_W  read address (= fetch_pc)
//  imem_rsp_valid in   1       read data valid (1 cycle pulse per accepted request)
//  imem_rsp_data  in   DATA_W  read data
//  instr_valid    out  1       buffer head valid
//  instr_ready    in   1       decoder consumes head
//  instr          out  DATA_W  head instruction
//  instr_pc       out  ADDR_W  address of head instruction
//  buf_full       out  1       buffer holds DEPTH entries
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, fetch_pc=RESET_PC, buffer empty, no request in flight;
//   imem_req_valid=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, buf_full=0.
//  FSM: IDLE, REQ, WAIT, DRAIN. space = (count < DEPTH).
//   IDLE : if fetch_en & space -> REQ.
//   REQ  : imem_req_valid=1 (only in REQ); on imem_req_ready: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1, -> WAIT.
//   WAIT : on imem_rsp_valid: push {req_pc, imem_rsp_data}; -> REQ if fetch_en & space after push/pop, else IDLE.
//   DRAIN: in-flight response owed but discarded; on imem_rsp_valid drop data, -> IDLE.
//  Request issued only when buffer has room for its response, so push never overflows.
//  fetch_pc wraps 16'hFFFF -> 16'h0000 (modulo 2^ADDR_W), no flag.
//  Latency: fetch_en rises in IDLE at cycle 0 -> imem_req_valid=1 at cycle 1; rsp_valid at cycle N ->
//   instr_valid=1 at cycle N+1 (buffer registered).
//  Output: instr_valid = count!=0; instr/instr_pc = head; pop when instr_valid & instr_ready.
//   Same-cycle push and pop allowed (count unchanged). Head stable while instr_valid & !instr_ready.
//  flush (highest priority, synchronous): buffer cleared (a same-cycle pop counts as consumed, a
//   same-cycle push is discarded), fetch_pc<=flush_pc; from WAIT (rsp not this cycle) -> DRAIN,
//   otherwise -> IDLE. In REQ the request is withdrawn even if ready=1 that cycle (no in-flight).
//   instr_valid=0 the cycle after flush. flush during DRAIN reloads fetch_pc, stays DRAIN.
//  imem_rsp_valid in IDLE/REQ (none outstanding) ignored. fetch_en=0 never cancels an in-flight request.
//  Reset mid-operation: everything cleared immediately; responses after reset release are ignored.
// TESTING
//  1 reset: reset=0 -> all outputs 0, imem_addr=16'h0000; release, fetch_en=1 -> req_valid next cycle, addr 0.
//  2 stream: mem returns 16'hA000+addr 1 cycle after accept, instr_ready=1 -> instr_pc 0,1,2,... with
//    instr 16'hA000,16'hA001,... in order, no gaps beyond 1-request-in-flight rate.
//  3 backpressure: instr_ready=0 -> exactly DEPTH entries, buf_full=1, req_valid stays 0; ready=1 -> resumes.
//  4 flush in WAIT: flush_pc=16'h0040 while rsp pending -> late rsp dropped, next instr_pc=16'h0040.
//  5 wrap: flush_pc=16'hFFFF -> instr_pc 16'hFFFF then 16'h0000.
//  6 reset mid-WAIT with buffer non-empty -> instr_valid=0 at once; stale rsp after release ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: issues word-addressed reads with one in flight and buffers {pc, instr} for decode.
// Latency: request 1 cycle after fetch_en; instr_valid 1 cycle after the imem response.
// Backpressure: a request is issued only when the buffer has room; flush redirects and drops in-flight data.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              buf_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] dat;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_pc_q;
  entry_t            buf_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop, req_fire, space_now, space_next;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A flush withdraws the request combinationally so memory never sees it accepted.
  assign imem_req_valid = (state_q == REQ) & ~flush;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign imem_addr      = fetch_pc_q;

  assign instr_valid = (count_q != '0);
  assign instr       = buf_q[rd_ptr_q].dat;
  assign instr_pc    = buf_q[rd_ptr_q].pc;
  assign buf_full    = (count_q == DEPTH_C);

  assign pop        = instr_valid & instr_ready;
  assign push       = (state_q == WAIT) & imem_rsp_valid & ~flush;
  assign count_d    = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
  assign space_now  = (count_q < DEPTH_C);
  assign space_next = (count_d < DEPTH_C);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fetch_en && space_now) state_d = REQ;
      REQ:     if (req_fire) state_d = WAIT;
      WAIT:    if (imem_rsp_valid) state_d = (fetch_en && space_next) ? REQ : IDLE;
      DRAIN:   if (imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // In DRAIN a flush only reloads the PC; the owed response still has to be absorbed.
    if (flush && state_q != DRAIN)
      state_d = (state_q == WAIT && !imem_rsp_valid) ? DRAIN : IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) buf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (flush)         fetch_pc_q <= flush_pc;
      else if (req_fire) fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
      if (req_fire) req_pc_q <= fetch_pc_q;
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) begin
          buf_q[wr_ptr_q] <= {req_pc_q, imem_rsp_data};
          wr_ptr_q        <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: memory model plus a scoreboard of expected {pc, instr} in program order.
module tb_instr_fetch_unit;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] flush_pc = '0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [DW-1:0] imem_rsp_data = '0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          buf_full;

  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;
  int unsigned mem_lat_min = 0, mem_lat_max = 0, mem_rdy_pct = 100;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] dat;
  } exp_t;

  exp_t          exp_q[$];
  logic [AW-1:0] model_pc;
  logic          prev_flush;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .flush(flush), .flush_pc(flush_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out or unexpected event at %0t", name, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: data = 16'hA000 + addr, response 1+lat cycles after accept.
  initial begin : mem_model
    logic          acc;
    logic [AW-1:0] acc_addr;
    logic          pend;
    logic [AW-1:0] pend_addr;
    int unsigned   pend_wait;
    pend = 1'b0; pend_addr = '0; pend_wait = 0;
    forever begin
      @(negedge clk);
      acc      = imem_req_valid && imem_req_ready && reset;
      acc_addr = imem_addr;
      @(posedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = DW'($urandom);
      if (acc) begin
        pend      = 1'b1;
        pend_addr = acc_addr;
        pend_wait = $urandom_range(mem_lat_max, mem_lat_min);
      end
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 16'hA000 + pend_addr;
          pend           = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      imem_req_ready = ($urandom_range(99, 0) < mem_rdy_pct);
    end
  end

  // Reference: the decoder must see consecutive PCs from the last reset/flush target, in order.
  initial begin : monitor
    exp_t e;
    model_pc   = '0;
    prev_flush = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        exp_q.delete();
        model_pc   = 16'h0000;
        prev_flush = 1'b0;
        continue;
      end
      if (prev_flush) check("valid_after_flush", 32'(instr_valid), 32'(0));
      if (buf_full) check("no_req_when_full", 32'(imem_req_valid), 32'(0));
      if (instr_valid && instr_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          fail_now("extra_instr");
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", 32'(instr_pc), 32'(e.pc));
          check("instr", 32'(instr), 32'(e.dat));
        end
      end
      if (flush) begin
        check("req_withdrawn_on_flush", 32'(imem_req_valid), 32'(0));
        exp_q.delete();
        model_pc = flush_pc;
      end else if (imem_req_valid && imem_req_ready) begin
        check("imem_addr", 32'(imem_addr), 32'(model_pc));
        exp_q.push_back('{pc: model_pc, dat: 16'hA000 + model_pc});
        model_pc = model_pc + 16'd1;
      end
      prev_flush = flush;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit            ok;
    int            p0;
    logic [AW-1:0] head;
    reset = 1'b1;
    #2;
    reset = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_valid", 32'(imem_req_valid), 32'(0));
    check("rst_imem_addr", 32'(imem_addr), 32'(0));
    check("rst_instr_valid", 32'(instr_valid), 32'(0));
    check("rst_instr", 32'(instr), 32'(0));
    check("rst_instr_pc", 32'(instr_pc), 32'(0));
    check("rst_buf_full", 32'(buf_full), 32'(0));

    // Release, fetch_en: request appears one cycle later at address 0
    step();
    reset = 1'b1; fetch_en = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    check("req_valid_cycle0", 32'(imem_req_valid), 32'(0));
    @(negedge clk);
    check("req_valid_cycle1", 32'(imem_req_valid), 32'(1));
    check("req_addr_cycle1", 32'(imem_addr), 32'(0));

    // Streaming at one request in flight
    p0 = n_pop;
    repeat (40) @(negedge clk);
    check("stream_rate_ok", 32'(n_pop - p0 >= 18), 32'(1));

    // Backpressure
    step();
    instr_ready = 1'b0;
    repeat (12) @(negedge clk);
    check("bp_buf_full", 32'(buf_full), 32'(1));
    check("bp_instr_valid", 32'(instr_valid), 32'(1));
    check("bp_req_valid", 32'(imem_req_valid), 32'(0));
    head = instr_pc;
    repeat (3) @(negedge clk);
    check("bp_head_stable", 32'(instr_pc), 32'(head));
    step();
    instr_ready = 1'b1;
    p0 = n_pop;
    repeat (10) @(negedge clk);
    check("bp_resumed", 32'(n_pop - p0 >= 4), 32'(1));

    // Flush while a response is pending
    mem_lat_min = 3; mem_lat_max = 3;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_req_accept");
    step();
    flush = 1'b1; flush_pc = 16'h0040;
    step();
    flush = 1'b0;
    mem_lat_min = 0; mem_lat_max = 0;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (instr_valid) begin ok = 1'b1; break; end
    end
    if (ok) check("flush_target_pc", 32'(instr_pc), 32'h0040);
    else fail_now("wait_flush_target");

    // PC wrap
    step();
    instr_ready = 1'b0; flush = 1'b1; flush_pc = 16'hFFFF;
    step();
    flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (buf_full) begin ok = 1'b1; break; end
    end
    if (ok) check("wrap_head_ffff", 32'(instr_pc), 32'hFFFF);
    else fail_now("wait_wrap_full");
    step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    @(negedge clk);
    check("wrap_head_0000", 32'(instr_pc), 32'h0000);
    check("wrap_valid", 32'(instr_valid), 32'(1));

    // Reset with a request in flight and a non-empty buffer
    mem_lat_min = 3; mem_lat_max = 3;
    step();
    flush = 1'b1; flush_pc = 16'h0100;
    step();
    flush = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (instr_valid && imem_req_valid && imem_req_ready) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("wait_mid_wait");
    step();
    reset = 1'b0; fetch_en = 1'b0;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'(0));
    check("async_rst_full", 32'(buf_full), 32'(0));
    @(negedge clk);
    check("async_rst_addr", 32'(imem_addr), 32'(0));
    step();
    reset = 1'b1;
    mem_lat_min = 0; mem_lat_max = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stale_rsp_ignored", 32'(instr_valid), 32'(0));
    end

    // Randomized traffic
    mem_lat_min = 0; mem_lat_max = 2; mem_rdy_pct = 70;
    for (int i = 0; i < 3000; i++) begin
      step();
      fetch_en    = ($urandom_range(7, 0) != 0);
      instr_ready = ($urandom_range(3, 0) != 0);
      flush       = ($urandom_range(39, 0) == 0);
      flush_pc    = ($urandom_range(3, 0) == 0) ? 16'hFFFE : AW'($urandom);
    end

    // Drain: everything owed must have been delivered
    step();
    fetch_en = 1'b0; flush = 1'b0; instr_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 32'(0));
    check("drain_instr_valid", 32'(instr_valid), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
